// File: rtl/freq_meter_if.sv
// Result bus of the gated frequency counter: measured count, overflow flag and
// the packed-BCD rendering, each with its own one-cycle update strobe.
interface freq_meter_if #(
    parameter int FREQ_W = 26
);
    logic [FREQ_W-1:0] freq_out;
    logic              freq_valid;
    logic              ovf;
    logic [31:0]       bcd_out;
    logic              bcd_valid;

    modport master (
        output freq_out,
        output freq_valid,
        output ovf,
        output bcd_out,
        output bcd_valid
    );

    modport slave (
        input freq_out,
        input freq_valid,
        input ovf,
        input bcd_out,
        input bcd_valid
    );
endinterface

// File: rtl/freq_meter.sv
// Gated frequency counter: counts synchronised rising edges of f_in per gate window.
// Define FREQ_METER_BCD_EN to build the double-dabble BCD converter; otherwise bcd_out/bcd_valid read 0.
module freq_meter #(
    parameter int GATE_CYCLES = 50_000_000,
    parameter int FREQ_W      = 26
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         f_in,
    freq_meter_if.master res
);
    localparam int                GW        = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GW-1:0]     GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [FREQ_W-1:0] ECNT_MAX  = {FREQ_W{1'b1}};

    logic              s1_r, s2_r, s3_r;
    logic              rise_s;
    logic [GW-1:0]     gcnt_r;
    logic              term_s;
    logic [FREQ_W-1:0] ecnt_r;
    logic              sat_r;
    logic [FREQ_W:0]   close_sum_s;
    logic [FREQ_W-1:0] freq_out_r;
    logic              freq_valid_r;
    logic              ovf_r;

    // Two-flop synchroniser followed by a delay flop for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
            s3_r <= 1'b0;
        end else begin
            s1_r <= f_in;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    assign rise_s      = s2_r & ~s3_r;
    assign term_s      = (gcnt_r == GATE_LAST);
    // A rise landing in the terminal cycle still belongs to the closing window
    assign close_sum_s = {1'b0, ecnt_r} + {{FREQ_W{1'b0}}, rise_s};

    // Gate window counter, wraps after the terminal cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            gcnt_r <= {GW{1'b0}};
        end else if (term_s) begin
            gcnt_r <= {GW{1'b0}};
        end else begin
            gcnt_r <= gcnt_r + GW'(1);
        end
    end

    // Saturating edge counter and result latch at window close
    always_ff @(posedge clk) begin
        if (rst) begin
            ecnt_r       <= {FREQ_W{1'b0}};
            sat_r        <= 1'b0;
            freq_out_r   <= {FREQ_W{1'b0}};
            freq_valid_r <= 1'b0;
            ovf_r        <= 1'b0;
        end else begin
            freq_valid_r <= term_s;
            if (term_s) begin
                freq_out_r <= close_sum_s[FREQ_W] ? ECNT_MAX : close_sum_s[FREQ_W-1:0];
                ovf_r      <= sat_r | close_sum_s[FREQ_W];
                ecnt_r     <= {FREQ_W{1'b0}};
                sat_r      <= 1'b0;
            end else if (rise_s) begin
                if (ecnt_r == ECNT_MAX) begin
                    sat_r <= 1'b1;
                end else begin
                    ecnt_r <= ecnt_r + FREQ_W'(1);
                end
            end
        end
    end

    assign res.freq_out   = freq_out_r;
    assign res.freq_valid = freq_valid_r;
    assign res.ovf        = ovf_r;

`ifdef FREQ_METER_BCD_EN
    localparam int            SW        = 32 + FREQ_W;
    localparam int            IW        = $clog2(FREQ_W + 1);
    localparam logic [IW-1:0] ITER_LAST = IW'(FREQ_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd_state_t;

    bcd_state_t    state_r, state_s;
    logic [SW-1:0] shreg_r;
    logic [SW-1:0] shift_next_s;
    logic [IW-1:0] iter_r;
    logic [31:0]   bcd_out_r;
    logic          bcd_valid_r;

    function automatic logic [31:0] dabble_adjust(input logic [31:0] digits);
        logic [31:0] adj;
        adj = digits;
        for (int k = 0; k < 8; k++) begin
            if (digits[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = digits[4*k +: 4] + 4'd3;
            end else begin
                adj[4*k +: 4] = digits[4*k +: 4];
            end
        end
        return adj;
    endfunction

    assign shift_next_s = {dabble_adjust(shreg_r[SW-1 -: 32]), shreg_r[FREQ_W-1:0]} << 1;

    // Converter state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Converter next-state logic; a strobe arriving mid-conversion is dropped
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (freq_valid_r) begin
                    state_s = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (iter_r == ITER_LAST) begin
                    state_s = DONE;
                end else begin
                    state_s = SHIFT;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Converter datapath: load, adjust-and-shift, publish
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_r     <= {SW{1'b0}};
            iter_r      <= {IW{1'b0}};
            bcd_out_r   <= 32'd0;
            bcd_valid_r <= 1'b0;
        end else begin
            bcd_valid_r <= (state_r == DONE);
            case (state_r)
                IDLE: begin
                    if (freq_valid_r) begin
                        shreg_r <= {32'd0, freq_out_r};
                        iter_r  <= {IW{1'b0}};
                    end
                end
                SHIFT: begin
                    shreg_r <= shift_next_s;
                    iter_r  <= iter_r + IW'(1);
                end
                DONE:    bcd_out_r <= shreg_r[SW-1 -: 32];
                default: iter_r    <= {IW{1'b0}};
            endcase
        end
    end

    assign res.bcd_out   = bcd_out_r;
    assign res.bcd_valid = bcd_valid_r;
`else
    assign res.bcd_out   = 32'd0;
    assign res.bcd_valid = 1'b0;
`endif
endmodule

// File: tb/tb_freq_meter.sv
// Scoreboard bench for freq_meter: two instances (26-bit and 8-bit result) share one
// random stimulus stream; a window-level edge-count model feeds per-instance queues.
module tb_freq_meter;
    localparam int G  = 1000;
    localparam int WA = 26;
    localparam int WB = 8;

    logic clk = 1'b0;
    logic rst;
    logic f_in;

    always #5 clk = ~clk;

    freq_meter_if #(.FREQ_W(WA)) bus_a ();
    freq_meter_if #(.FREQ_W(WB)) bus_b ();

    freq_meter #(.GATE_CYCLES(G), .FREQ_W(WA)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .f_in(f_in),
        .res (bus_a)
    );

    freq_meter #(.GATE_CYCLES(G), .FREQ_W(WB)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .f_in(f_in),
        .res (bus_b)
    );

    typedef struct {
        longint val;
        bit     ovf;
        longint t;
    } exp_t;

    exp_t   fq_a[$], fq_b[$], bq_a[$], bq_b[$];
    int     vectors     = 0;
    int     miscompares = 0;
    longint edges       = 0;

    // Reference model state: n = edges since the reset edge, cnt = rises in the open window
    int     n      = 0;
    longint cnt    = 0;
    bit     prev_x = 1'b0;
    bit     pushed = 1'b0;
    longint last_a = 0;
    longint last_b = 0;

    always @(posedge clk) edges <= edges + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual 0x%0h required 0x%0h (edge %0d)", nm, act, exp, edges);
        end
    endtask

    function automatic longint bcd_of(input longint v);
        longint r = 0;
        longint x = v;
        for (int d = 0; d < 8; d++) begin
            r = r | ((x % 10) << (4 * d));
            x = x / 10;
        end
        return r;
    endfunction

    // Close a window: saturate the true rise count to each instance's width
    task automatic push_window();
        exp_t   e;
        longint max_a = (longint'(1) << WA) - 1;
        longint max_b = (longint'(1) << WB) - 1;
        e.t   = edges + 3;
        e.val = (cnt > max_a) ? max_a : cnt;
        e.ovf = (cnt > max_a);
        fq_a.push_back(e);
        last_a = e.val;
`ifdef FREQ_METER_BCD_EN
        e.t   = edges + 3 + WA + 2;
        e.val = bcd_of(last_a);
        e.ovf = 1'b0;
        bq_a.push_back(e);
`endif
        e.t   = edges + 3;
        e.val = (cnt > max_b) ? max_b : cnt;
        e.ovf = (cnt > max_b);
        fq_b.push_back(e);
        last_b = e.val;
`ifdef FREQ_METER_BCD_EN
        e.t   = edges + 3 + WB + 2;
        e.val = bcd_of(last_b);
        e.ovf = 1'b0;
        bq_b.push_back(e);
`endif
    endtask

    // Drive f_in for the next edge n; a 0->1 step seen at edge n is counted in the cycle after edge n+1
    task automatic step(input bit v);
        int m;
        f_in   = v;
        n++;
        m      = n + 1;
        cnt    = cnt + ((v && !prev_x) ? 1 : 0);
        prev_x = v;
        pushed = 1'b0;
        if ((m % G) == G - 1) begin
            push_window();
            cnt    = 0;
            pushed = 1'b1;
        end
        @(negedge clk);
    endtask

    function automatic bit gen(input int mode, input int per, input int k, input bit pv);
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return ((k % per) < (per / 2));
            3:       return ~pv;
            4:       return 1'($urandom_range(0, 1));
            default: return 1'b0;
        endcase
    endfunction

    task automatic run(input int ncyc, input int mode, input int per);
        bit v = 1'b0;
        for (int k = 0; k < ncyc; k++) begin
            v = gen(mode, per, k, v);
            step(v);
        end
    endtask

    task automatic close_window(input int mode, input int per);
        bit v = 1'b0;
        int k = 0;
        do begin
            v = gen(mode, per, k, v);
            step(v);
            k++;
        end while (!pushed);
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        f_in   = 1'($urandom_range(0, 1));
        fq_a.delete();
        fq_b.delete();
        bq_a.delete();
        bq_b.delete();
        n      = 0;
        cnt    = 0;
        prev_x = 1'b0;
        last_a = 0;
        last_b = 0;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_freq_a", bus_a.freq_out, 0);
        chk("rst_valid_a", bus_a.freq_valid, 0);
        chk("rst_ovf_a", bus_a.ovf, 0);
        chk("rst_bcd_a", bus_a.bcd_out, 0);
        chk("rst_bcdv_a", bus_a.bcd_valid, 0);
        chk("rst_freq_b", bus_b.freq_out, 0);
        chk("rst_ovf_b", bus_b.ovf, 0);
        chk("rst_bcd_b", bus_b.bcd_out, 0);
    endtask

    // Monitor: every result strobe pops the oldest expectation for that instance
    always @(negedge clk) begin
        exp_t e;
        if (bus_a.freq_valid === 1'b1) begin
            if (fq_a.size() == 0) chk("freq_a_unexpected", 1, 0);
            else begin
                e = fq_a.pop_front();
                chk("freq_a", bus_a.freq_out, e.val);
                chk("ovf_a", bus_a.ovf, e.ovf);
                chk("freq_a_time", edges, e.t);
            end
        end
        if (bus_b.freq_valid === 1'b1) begin
            if (fq_b.size() == 0) chk("freq_b_unexpected", 1, 0);
            else begin
                e = fq_b.pop_front();
                chk("freq_b", bus_b.freq_out, e.val);
                chk("ovf_b", bus_b.ovf, e.ovf);
                chk("freq_b_time", edges, e.t);
            end
        end
`ifdef FREQ_METER_BCD_EN
        if (bus_a.bcd_valid === 1'b1) begin
            if (bq_a.size() == 0) chk("bcd_a_unexpected", 1, 0);
            else begin
                e = bq_a.pop_front();
                chk("bcd_a", bus_a.bcd_out, e.val);
                chk("bcd_a_time", edges, e.t);
            end
        end
        if (bus_b.bcd_valid === 1'b1) begin
            if (bq_b.size() == 0) chk("bcd_b_unexpected", 1, 0);
            else begin
                e = bq_b.pop_front();
                chk("bcd_b", bus_b.bcd_out, e.val);
                chk("bcd_b_time", edges, e.t);
            end
        end
`else
        if (bus_a.bcd_valid !== 1'b0 || bus_b.bcd_valid !== 1'b0) chk("bcd_valid_tied", 1, 0);
`endif
    end

    initial begin
        rst  = 1'b1;
        f_in = 1'b0;
        @(negedge clk);
        do_reset();

        run(3 * G, 2, 50);
        run(G, 0, 1);
        run(2 * G, 1, 1);
        run(2 * G, 3, 1);
        run(2 * G, 0, 1);
        for (int r = 0; r < 4; r++) run($urandom_range(300, 1500), 2, $urandom_range(2, 60));
        run(1500, 4, 1);

        // Reset in the cycle where the gate counter reads 600, with rises in flight
        while ((n % G) != 600) step(gen(2, 10, n, 1'b0));
        do_reset();
        run(2 * G + 300, 2, 30);

        // A single rise counted exactly in the terminal cycle
        close_window(0, 1);
        while (((n + 2) % G) != G - 1) step(1'b0);
        step(1'b1);
        close_window(1, 1);

        for (int k = 0; k < 40; k++) @(negedge clk);
        chk("drain_freq_a", fq_a.size(), 0);
        chk("drain_freq_b", fq_b.size(), 0);
        chk("drain_bcd_a", bq_a.size(), 0);
        chk("drain_bcd_b", bq_b.size(), 0);
        chk("hold_freq_a", bus_a.freq_out, last_a);
        chk("hold_freq_b", bus_b.freq_out, last_b);
`ifdef FREQ_METER_BCD_EN
        chk("hold_bcd_a", bus_a.bcd_out, bcd_of(last_a));
`else
        chk("tied_bcd_a", bus_a.bcd_out, 0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
